// File: rtl/calc_op_scheduler.sv
// calc_op_scheduler: sequences the sqrt/mul/div units for one requester,
// with clear/launch pulses, a DONE timeout, and a VALID/ERR response held until RD_ACK.
module calc_op_scheduler #(
    parameter int W       = 16,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req,
    input  logic [1:0]   op,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic         ack,
    output logic         busy,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out,
    output logic [2:0]   unit_clr,
    output logic [2:0]   init_u,
    input  logic [2:0]   done_u,
    input  logic [W-1:0] res_sqrt,
    input  logic [W-1:0] res_mul,
    input  logic [W-1:0] res_div,
    output logic [W-1:0] result,
    output logic         valid,
    output logic         err,
    input  logic         rd_ack
);
    typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic          err_q, err_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [2:0]    sel;
    logic [W-1:0]  res_sel;

    assign sel     = op_q == 2'd0 ? 3'b001 : op_q == 2'd1 ? 3'b010 : op_q == 2'd2 ? 3'b100 : 3'b000;
    assign res_sel = op_q == 2'd0 ? res_sqrt : op_q == 2'd1 ? res_mul : res_div;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (req) begin
                op_d = op;
                a_d  = opa;
                b_d  = opb;
                // Illegal opcode skips the units entirely and reports straight away
                if (&op) begin
                    state_d = RESP;
                    res_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    state_d = CLEAR;
                end
            end
            CLEAR:  state_d = LAUNCH;
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (|(done_u & sel)) begin
                res_d   = res_sel;
                err_d   = 1'b0;
                state_d = RESP;
            end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                res_d   = '0;
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + TW'(1);
            end
            RESP: if (rd_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = state_q != IDLE;
    assign ack      = state_q == CLEAR;
    assign unit_clr = ack ? sel : 3'b000;
    assign init_u   = state_q == LAUNCH ? sel : 3'b000;
    assign valid    = state_q == RESP;
    assign a_out    = a_q;
    assign b_out    = b_q;
    assign result   = res_q;
    assign err      = err_q;
endmodule

// File: tb/tb_calc_op_scheduler.sv
// tb_calc_op_scheduler: directed stimulus with simple unit models, a cycle-timeline
// reference model checked every cycle, and literal checks on key results and latencies.
module tb_calc_op_scheduler;
    localparam int W = 16;
    localparam int TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0;
    logic [1:0]   op = '0;
    logic [W-1:0] opa = '0, opb = '0;
    logic         ack, busy, valid, err;
    logic [W-1:0] a_out, b_out, result;
    logic [2:0]   unit_clr, init_u;
    logic [2:0]   done_r = '0;
    logic [W-1:0] res_sqrt = '0, res_mul = '0, res_div = '0;
    logic         rd_ack = 1'b0;

    int tests = 0;
    int fails = 0;
    int udly[3] = '{0, 0, 0};
    int ucnt[3] = '{0, 0, 0};

    calc_op_scheduler #(.W(W), .TIMEOUT(TIMEOUT), .TW(7)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .opa(opa), .opb(opb),
        .ack(ack), .busy(busy), .a_out(a_out), .b_out(b_out),
        .unit_clr(unit_clr), .init_u(init_u), .done_u(done_r),
        .res_sqrt(res_sqrt), .res_mul(res_mul), .res_div(res_div),
        .result(result), .valid(valid), .err(err), .rd_ack(rd_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Unit models: DONE rises udly cycles after INIT (0 = never), held until UNIT_CLR
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (unit_clr[i]) done_r[i] <= 1'b0;
            if (init_u[i]) ucnt[i] <= udly[i];
            else if (ucnt[i] > 0) begin
                ucnt[i] <= ucnt[i] - 1;
                if (ucnt[i] == 1) done_r[i] <= 1'b1;
            end
        end
    end

    // Reference model: mode 0 idle, 1 busy (age = cycles since acceptance), 2 responding
    int           m_mode = 0, m_age = 0;
    logic [1:0]   m_op = '0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic         m_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_age <= 0; m_op <= '0; m_a <= '0; m_b <= '0; m_res <= '0; m_err <= 1'b0;
        end else if (m_mode == 0) begin
            if (req) begin
                m_op <= op; m_a <= opa; m_b <= opb;
                if (op == 2'd3) begin
                    m_mode <= 2; m_err <= 1'b1; m_res <= '0;
                end else begin
                    m_mode <= 1; m_age <= 1;
                end
            end
        end else if (m_mode == 1) begin
            if (m_age >= 3 && ((done_r >> m_op) & 3'b001) != 0) begin
                m_res  <= m_op == 2'd0 ? res_sqrt : m_op == 2'd1 ? res_mul : res_div;
                m_err  <= 1'b0;
                m_mode <= 2;
            end else if (m_age - 3 == TIMEOUT - 1) begin
                m_res <= '0; m_err <= 1'b1; m_mode <= 2;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (rd_ack) begin
            m_mode <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_busy", busy, m_mode != 0);
            chk("m_valid", valid, m_mode == 2);
            chk("m_ack", ack, m_mode == 1 && m_age == 1);
            chk("m_unit_clr", unit_clr, (m_mode == 1 && m_age == 1) ? (3'b001 << m_op) : 3'b000);
            chk("m_init_u", init_u, (m_mode == 1 && m_age == 2) ? (3'b001 << m_op) : 3'b000);
            chk("m_a_out", a_out, m_a);
            chk("m_b_out", b_out, m_b);
            chk("m_result", result, m_res);
            chk("m_err", err, m_err);
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int wait_exp, input logic [W-1:0] exp_res, input logic exp_err,
                          input int hold);
        int n;
        @(negedge clk);
        req = 1'b1; op = o; opa = a; opb = b;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        chk("lit_ack", ack, o != 2'd3);
        chk("lit_unit_clr", unit_clr, o == 2'd3 ? 3'b000 : 3'b001 << o);
        if (o != 2'd3) begin
            @(negedge clk);
            n = 1;
            chk("lit_init_u", init_u, 3'b001 << o);
        end
        while (!valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("lit_latency", n, wait_exp);
        chk("lit_result", result, exp_res);
        chk("lit_err", err, exp_err);
        repeat (hold) begin
            @(negedge clk);
            chk("lit_hold", result, exp_res);
        end
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        chk("lit_idle_valid", valid, 1'b0);
        chk("lit_idle_busy", busy, 1'b0);
    endtask

    initial begin
        int n, acks;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_result", result, 16'h0000);
        #1 rst_n = 1'b1;

        // Reset in the middle of WAIT with sqrt launched
        @(negedge clk);
        req = 1'b1; op = 2'd0; opa = 16'h0051; opb = 16'h0000;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_valid", valid, 1'b0);
        chk("arst_a_out", a_out, 16'h0000);
        chk("arst_init", init_u, 3'b000);
        chk("arst_clr", unit_clr, 3'b000);
        @(negedge clk);
        #1 rst_n = 1'b1;

        udly[0] = 10; res_sqrt = 16'h0009;
        run_op(2'd0, 16'h0051, 16'h0000, 12, 16'h0009, 1'b0, 0);
        udly[1] = 3; res_mul = 16'h002A;
        run_op(2'd1, 16'h0007, 16'h0006, 5, 16'h002A, 1'b0, 0);
        udly[2] = 0; res_div = 16'h1234;
        run_op(2'd2, 16'h0064, 16'h0007, 2 + TIMEOUT, 16'h0000, 1'b1, 0);
        udly[2] = TIMEOUT; res_div = 16'h000A;
        run_op(2'd2, 16'h0032, 16'h0005, 2 + TIMEOUT, 16'h000A, 1'b0, 0);
        run_op(2'd3, 16'h0005, 16'h0005, 0, 16'h0000, 1'b1, 2);

        // REQ held high across an operation and a 5-cycle RESP
        udly[1] = 3; res_mul = 16'h002A;
        @(negedge clk);
        req = 1'b1; op = 2'd1; opa = 16'h0007; opb = 16'h0006;
        n = 0; acks = 0;
        while (!valid && n < 200) begin
            @(negedge clk);
            n++;
            acks += int'(ack);
        end
        chk("held_latency", n, 6);
        repeat (5) begin
            @(negedge clk);
            acks += int'(ack);
            chk("held_result", result, 16'h002A);
        end
        chk("held_acks", acks, 1);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        chk("held_idle", busy, 1'b0);
        @(negedge clk);
        req = 1'b0;
        chk("held_reaccept", ack, 1'b1);
        n = 0;
        while (!valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("held2_latency", n, 5);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/calc_op_scheduler.md
Name: calc_op_scheduler

Overview:
- Sequences the calculator's three shared arithmetic units (square root, multiplier, divider) for a single requester (keypad/front-end FSM).
- Latches the request and operands, clears the selected unit and pulses its INIT.
- Waits for that unit's DONE with a timeout, then captures the result.
- Holds the result with VALID until the requester acknowledges.
- Units whose FSM parks in a terminal state are returned to start by a one-cycle UNIT_CLR before every launch.

Parameters:
- W, 16, operand/result width
- TIMEOUT, 64, max cycles spent in WAIT before declaring an error (>=2)
- TW, 7, width of timeout counter (must hold TIMEOUT-1)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- REQ  in  1  operation request, sampled only in IDLE
- OP  in  2  00=sqrt, 01=mul, 10=div, 11=illegal
- OPA  in  W  operand A
- OPB  in  W  operand B (ignored for sqrt)
- ACK  out  1  request-accepted pulse
- BUSY  out  1  high in every state except IDLE
- A_OUT  out  W  latched operand A to all units
- B_OUT  out  W  latched operand B to all units
- UNIT_CLR  out  3  per-unit clear pulse, bit0 sqrt, bit1 mul, bit2 div
- INIT_U  out  3  per-unit start pulse, same bit mapping
- DONE_U  in  3  per-unit done level, same bit mapping
- RES_SQRT  in  W  sqrt result
- RES_MUL  in  W  mul result (low W bits)
- RES_DIV  in  W  div quotient
- RESULT  out  W  captured result, 0 on error
- VALID  out  1  result/status valid
- ERR  out  1  qualifies VALID: timeout or illegal OP
- RD_ACK  in  1  requester consumed result

Behaviour:
- Reset (RST_N low, async): state=IDLE; opcode/operand/result registers, counter, ERR cleared. All outputs are 0 during and after reset. Reset mid-operation abandons the operation with no VALID. Units are not cleared by this block on reset.
- Moore outputs are decoded from state. RESULT, ERR, A_OUT and B_OUT come from registers.
- States are IDLE, CLEAR, LAUNCH, WAIT, RESP.
- IDLE:
  - REQ=1 at edge: latch OP/OPA/OPB.
  - OP=11: go to RESP with ERR=1, RESULT=0.
  - Otherwise go to CLEAR.
  - REQ=0: stay in IDLE.
- CLEAR (1 cycle): ACK=1; UNIT_CLR[sel]=1; go to LAUNCH.
  - Illegal-OP path: ACK is not asserted; VALID+ERR is the only response.
- LAUNCH (1 cycle): INIT_U[sel]=1; counter=0; go to WAIT.
- WAIT, evaluated at each edge:
  - DONE_U[sel]=1: RESULT<=RES_sel, ERR<=0, go to RESP.
  - Else counter==TIMEOUT-1: RESULT<=0, ERR<=1, go to RESP.
  - Else counter++.
  - DONE and timeout in the same cycle: DONE wins.
  - DONE bits of non-selected units are ignored.
- RESP: VALID=1, and RESULT/ERR are held stable. RD_ACK=1 at edge: go to IDLE. VALID drops the next cycle.
- REQ is ignored (not queued) whenever state is not IDLE. REQ still high in IDLE after RESP starts a new operation.
- Latency, with acceptance edge T: ACK and UNIT_CLR in cycle T+1, INIT in T+2, first WAIT cycle T+3. DONE seen at edge k gives VALID from cycle k+1.
- A_OUT/B_OUT are stable from CLEAR through RESP; they change only on acceptance.
- At most one bit of UNIT_CLR or INIT_U is ever high. Both are single-cycle pulses.

Test Plan:
- Reset mid-WAIT (sqrt launched, RST_N low for 1 cycle) -> IDLE, BUSY=0, VALID=0, all outputs 0 immediately (async).
- OP=00, OPA=0x0051, sqrt model raises DONE_U[0] 10 cycles after INIT with RES_SQRT=0x0009. Required response:
  - ACK at T+1, UNIT_CLR=001 at T+1, INIT_U=001 at T+2.
  - VALID=1, RESULT=0x0009, ERR=0 until RD_ACK; then IDLE.
- OP=01, OPA=0x0007, OPB=0x0006, DONE_U=011 raised together (stale sqrt DONE) -> UNIT_CLR/INIT_U=010 only; RESULT=0x002A.
- OP=10 with divider never asserting DONE, TIMEOUT=64 -> exactly 64 WAIT cycles, then VALID=1, ERR=1, RESULT=0.
- OP=11 -> no ACK, no UNIT_CLR/INIT_U pulse; VALID=1, ERR=1 on the cycle after acceptance.
- REQ held high through an operation with RD_ACK held low 5 cycles in RESP -> RESULT stable for those cycles, no second ACK. New operation accepted on the first IDLE cycle after RD_ACK.
